// File: rtl/dte_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dte_pkg
//  Description : Shared definitions for the DTE20 diagnostic-function engine:
//                diag function code constants, the 36-bit PDP-10 word type
//                (bit 0 = MSB, bit 35 = LSB), the engine state encoding and
//                helpers for sizing the cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
package dte_pkg;

    // Bit 6 of the function code selects a read (0o100-0o177) vs a write.
    localparam int         DIAG_READ_BIT = 6;
    // Function code that returns the hardware options word.
    localparam logic [6:0] DIAG_HWOPT    = 7'o177;

    // PDP-10 word, numbered [0:35] with bit 35 least significant.
    typedef logic [0:35] word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage : dte_pkg
`default_nettype wire

// File: rtl/dte_diag_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : dte_diag_port_if
//  Description : Command port and EBUS signals of the diagnostic engine.
//                slave  : the engine (dte_diag_port).
//                master : the surrounding system (front end + EBUS mux),
//                         which issues commands and returns muxed EBUS data.
//  Signals     : cmd_valid/cmd_ready/cmd_func/cmd_wdata  command request
//                ebus_func/ebus_diag_strobe              diag cycle control
//                ebus_driving/ebus_data_out              EBUSdriver
//                ebus_data_in                            muxed EBUS.data
//                resp_valid/resp_rdata                   completion
//  Revision    : 1.0  initial release
// ============================================================================
interface dte_diag_port_if;
    import dte_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_func;
    word_t      cmd_wdata;

    logic [6:0] ebus_func;
    logic       ebus_diag_strobe;
    logic       ebus_driving;
    word_t      ebus_data_out;
    word_t      ebus_data_in;

    logic       resp_valid;
    word_t      resp_rdata;

    modport slave (
        input  cmd_valid, cmd_func, cmd_wdata, ebus_data_in,
        output cmd_ready, ebus_func, ebus_diag_strobe, ebus_driving,
               ebus_data_out, resp_valid, resp_rdata
    );

    modport master (
        output cmd_valid, cmd_func, cmd_wdata, ebus_data_in,
        input  cmd_ready, ebus_func, ebus_diag_strobe, ebus_driving,
               ebus_data_out, resp_valid, resp_rdata
    );

endinterface : dte_diag_port_if
`default_nettype wire

// File: rtl/dte_strobe_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dte_strobe_timer
//  Description : Down-counter shared by the SETUP, STROBE and HOLD states.
//                Loading N on the edge that enters a state makes expire_o
//                assert in that state's N-th cycle.
//  Ports       : clk, CROBAR_N (async active-low reset)
//                load_i / load_val_i : reload the counter
//                expire_o            : current cycle is the last one
//  Revision    : 1.0  initial release
// ============================================================================
module dte_strobe_timer #(
    parameter int WIDTH = 2
) (
    input  wire logic             clk,
    input  wire logic             CROBAR_N,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    output logic                  expire_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    // <= 1 rather than == 1 so a stray zero can never stall the engine.
    assign expire_o = (count_q <= WIDTH'(1));

endmodule : dte_strobe_timer
`default_nettype wire

// File: rtl/dte_diag_port.sv
`default_nettype none
// ============================================================================
//  Module      : dte_diag_port
//  Description : DTE20 diagnostic-function engine. Runs one front-end diag
//                read or write as SETUP -> STROBE -> HOLD -> DONE on the
//                shared EBUS. Writes drive the EBUSdriver; reads capture the
//                muxed EBUS data on the last strobe edge.
//  Ports       : clk        system clock
//                CROBAR_N   asynchronous active-low reset
//                hw_options hardware options word, bits [18:35]
//                bus        dte_diag_port_if.slave (command port + EBUS)
//  Options     : DTE_HWOPT_READ_EN - when defined, function 0o177 completes
//                locally with {18'b0, hw_options} and no EBUS cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module dte_diag_port
    import dte_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  wire logic          clk,
    input  wire logic          CROBAR_N,
    input  wire logic [18:35]  hw_options,
    dte_diag_port_if.slave     bus
);

    localparam int MAX_CYC = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W   = cnt_width(MAX_CYC);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ONE_LOAD    = CNT_W'(1);

    if (STROBE_CYCLES < 1) begin : g_bad_strobe
        $error("dte_diag_port: STROBE_CYCLES must be at least 1");
    end

    state_t     state_q, state_d;
    logic [6:0] func_q,  func_d;
    word_t      wdata_q, wdata_d;
    word_t      cap_q,   cap_d;
    word_t      rdata_q, rdata_d;
    logic       local_q, local_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;
    logic             hwopt_hit;
    logic             is_read;
    logic             active;

`ifdef DTE_HWOPT_READ_EN
    assign hwopt_hit = (bus.cmd_func == DIAG_HWOPT);
`else
    assign hwopt_hit = 1'b0;
`endif

    assign is_read = func_q[DIAG_READ_BIT];

    dte_strobe_timer #(.WIDTH(CNT_W)) u_timer (
        .clk        (clk),
        .CROBAR_N   (CROBAR_N),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state_q <= IDLE;
            func_q  <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            local_q <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            local_q <= local_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        wdata_d  = wdata_q;
        cap_d    = cap_q;
        rdata_d  = rdata_q;
        local_d  = local_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    func_d   = bus.cmd_func;
                    wdata_d  = bus.cmd_wdata;
                    local_d  = hwopt_hit;
                    tmr_load = 1'b1;
                    if (hwopt_hit) begin
                        // Local completion borrows one HOLD cycle with all
                        // EBUS outputs suppressed, giving the 2-cycle latency.
                        state_d = HOLD;
                        tmr_val = ONE_LOAD;
                    end else if (SETUP_CYCLES > 0) begin
                        state_d = SETUP;
                        tmr_val = SETUP_LOAD;
                    end else begin
                        state_d = STROBE;
                        tmr_val = STROBE_LOAD;
                    end
                end
            end
            SETUP: begin
                if (tmr_expire) begin
                    state_d  = STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LOAD;
                end
            end
            STROBE: begin
                if (tmr_expire) begin
                    if (is_read) begin
                        cap_d = bus.ebus_data_in;
                    end
                    if (HOLD_CYCLES > 0) begin
                        state_d  = HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            HOLD: begin
                if (tmr_expire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The response word only changes as DONE is entered, so it stays
        // stable from one response to the next. cap_d covers HOLD_CYCLES = 0.
        if ((state_d == DONE) && (state_q != DONE)) begin
            if (local_q) begin
                rdata_d = {18'b0, hw_options};
            end else if (is_read) begin
                rdata_d = cap_d;
            end else begin
                rdata_d = '0;
            end
        end
    end

    // Outputs decode the registered state, so the async reset clears them
    // in the same cycle it is asserted.
    assign active = ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD))
                    && !local_q;

    assign bus.cmd_ready        = (state_q == IDLE);
    assign bus.ebus_func        = active ? func_q : 7'd0;
    assign bus.ebus_diag_strobe = (state_q == STROBE) && !local_q;
    assign bus.ebus_driving     = active && !is_read;
    assign bus.ebus_data_out    = (active && !is_read) ? wdata_q : '0;
    assign bus.resp_valid       = (state_q == DONE);
    assign bus.resp_rdata       = rdata_q;

endmodule : dte_diag_port
`default_nettype wire

// File: tb/tb_dte_diag_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dte_diag_port
//  Description : Directed bench for dte_diag_port. u_dut uses the default
//                timing (1/2/1); u_dut_sweep uses SETUP=0, STROBE=4, HOLD=1.
//                Cycle numbering: C0 is the accept cycle, Cn is n cycles on.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dte_diag_port;
    import dte_pkg::*;

    logic          clk = 1'b0;
    logic          CROBAR_N = 1'b0;
    logic [18:35]  hw_options = '0;
    int            errors = 0;
    int            checks = 0;

    dte_diag_port_if if0 ();
    dte_diag_port_if if1 ();

    dte_diag_port u_dut (
        .clk        (clk),
        .CROBAR_N   (CROBAR_N),
        .hw_options (hw_options),
        .bus        (if0)
    );

    dte_diag_port #(
        .SETUP_CYCLES  (0),
        .STROBE_CYCLES (4),
        .HOLD_CYCLES   (1)
    ) u_dut_sweep (
        .clk        (clk),
        .CROBAR_N   (CROBAR_N),
        .hw_options (hw_options),
        .bus        (if1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        #2;
        obs = {if0.ebus_func, if0.ebus_diag_strobe, if0.ebus_driving, if0.resp_valid, if0.cmd_ready};
        checks++;
        if (obs !== 11'b0000000_0001) begin
            errors++; $display("FAIL reset_ctrl obs=%b exp=%b", obs, 11'b0000000_0001);
        end
        checks++;
        if (if0.ebus_data_out !== 36'o0 || if0.resp_rdata !== 36'o0) begin
            errors++; $display("FAIL reset_data out=%o rdata=%o exp=0", if0.ebus_data_out, if0.resp_rdata);
        end
        tick();
        tick();
        CROBAR_N = 1'b1;
        tick();
    endtask

    task automatic test_read();
        logic [10:0] obs, exp;
        word_t rd_val;
        rd_val = 36'o777000_000777;
        if0.cmd_valid = 1'b1; if0.cmd_func = 7'o105; if0.cmd_wdata = 36'o707070_707070;
        checks++;
        if (if0.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL read_accept ready=%b exp=1", if0.cmd_ready);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin if0.cmd_valid = 1'b0; if0.cmd_func = 7'o000; end
            if0.ebus_data_in = (c == 3) ? rd_val : 36'o123123_123123;
            obs = {if0.ebus_func, if0.ebus_diag_strobe, if0.ebus_driving, if0.resp_valid, if0.cmd_ready};
            exp = {(c >= 1 && c <= 4) ? 7'o105 : 7'o000, (c == 2 || c == 3), 1'b0, (c == 5), (c == 6)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL read_c%0d obs=%b exp=%b", c, obs, exp);
            end
            checks++;
            if (if0.ebus_data_out !== 36'o0) begin
                errors++; $display("FAIL read_dout_c%0d got=%o exp=0", c, if0.ebus_data_out);
            end
            if (c >= 5) begin
                checks++;
                if (if0.resp_rdata !== rd_val) begin
                    errors++; $display("FAIL read_rdata_c%0d got=%o exp=%o", c, if0.resp_rdata, rd_val);
                end
            end
        end
    endtask

    task automatic test_write();
        logic [10:0] obs, exp;
        word_t wd, exp_d;
        int nstb, lat;
        wd = 36'o123456_701234; nstb = 0; lat = -1;
        if0.cmd_valid = 1'b1; if0.cmd_func = 7'o042; if0.cmd_wdata = wd;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin if0.cmd_valid = 1'b0; if0.cmd_func = 7'o105; if0.cmd_wdata = 36'o0; end
            if (if0.ebus_diag_strobe === 1'b1) nstb++;
            if (if0.resp_valid === 1'b1 && lat < 0) lat = c;
            obs = {if0.ebus_func, if0.ebus_diag_strobe, if0.ebus_driving, if0.resp_valid, if0.cmd_ready};
            exp = {(c >= 1 && c <= 4) ? 7'o042 : 7'o000, (c == 2 || c == 3), (c >= 1 && c <= 4), (c == 5), (c == 6)};
            exp_d = (c >= 1 && c <= 4) ? wd : 36'o0;
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL write_c%0d obs=%b exp=%b", c, obs, exp);
            end
            checks++;
            if (if0.ebus_data_out !== exp_d) begin
                errors++; $display("FAIL write_dout_c%0d got=%o exp=%o", c, if0.ebus_data_out, exp_d);
            end
            if (c == 5) begin
                checks++;
                if (if0.resp_rdata !== 36'o0) begin
                    errors++; $display("FAIL write_rdata got=%o exp=0", if0.resp_rdata);
                end
            end
        end
        checks++;
        if (nstb != 2 || lat != 5) begin
            errors++; $display("FAIL write_timing strobes=%0d lat=%0d exp 2/5", nstb, lat);
        end
    endtask

    task automatic test_back_to_back_busy();
        int nresp;
        nresp = 0;
        if0.cmd_valid = 1'b1; if0.cmd_func = 7'o033; if0.cmd_wdata = 36'o1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) if0.cmd_valid = 1'b0;
            if (c == 2) begin if0.cmd_valid = 1'b1; if0.cmd_func = 7'o044; if0.cmd_wdata = 36'o2; end
            if (c == 7) if0.cmd_valid = 1'b0;
            if (if0.resp_valid === 1'b1) nresp++;
            if (c == 2 || c == 5) begin
                checks++;
                if (if0.cmd_ready !== 1'b0) begin
                    errors++; $display("FAIL busy_ready_c%0d got=%b exp=0", c, if0.cmd_ready);
                end
            end
            if (c == 4) begin
                checks++;
                if (if0.ebus_func !== 7'o033 || if0.ebus_data_out !== 36'o1) begin
                    errors++; $display("FAIL busy_hold func=%o data=%o exp 033/1", if0.ebus_func, if0.ebus_data_out);
                end
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (nresp != 1) begin
                    errors++; $display("FAIL busy_resp_c%0d count=%0d exp=1", c, nresp);
                end
            end
            if (c == 6) begin
                checks++;
                if (if0.cmd_ready !== 1'b1) begin
                    errors++; $display("FAIL busy_idle ready=%b exp=1", if0.cmd_ready);
                end
            end
            if (c == 7) begin
                checks++;
                if (if0.ebus_func !== 7'o044 || if0.ebus_data_out !== 36'o2) begin
                    errors++; $display("FAIL busy_second func=%o data=%o exp 044/2", if0.ebus_func, if0.ebus_data_out);
                end
            end
            if (c == 11) begin
                checks++;
                if (if0.resp_valid !== 1'b1 || nresp != 2) begin
                    errors++; $display("FAIL busy_second_resp valid=%b count=%0d exp 1/2", if0.resp_valid, nresp);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        logic [10:0] obs;
        int nresp;
        nresp = 0;
        if0.cmd_valid = 1'b1; if0.cmd_func = 7'o061; if0.cmd_wdata = 36'o555;
        tick();
        if0.cmd_valid = 1'b0;
        tick();
        #2;
        checks++;
        if (if0.ebus_diag_strobe !== 1'b1 || if0.ebus_driving !== 1'b1) begin
            errors++; $display("FAIL rst_pre strobe=%b drive=%b exp 1/1", if0.ebus_diag_strobe, if0.ebus_driving);
        end
        CROBAR_N = 1'b0;
        #1;
        obs = {if0.ebus_func, if0.ebus_diag_strobe, if0.ebus_driving, if0.resp_valid, if0.cmd_ready};
        checks++;
        if (obs !== 11'b0000000_0001 || if0.ebus_data_out !== 36'o0) begin
            errors++; $display("FAIL rst_mid obs=%b data=%o exp=%b/0", obs, if0.ebus_data_out, 11'b0000000_0001);
        end
        tick();
        CROBAR_N = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (if0.resp_valid === 1'b1) nresp++;
        end
        checks++;
        if (nresp != 0 || if0.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_noresp count=%0d ready=%b exp 0/1", nresp, if0.cmd_ready);
        end
    endtask

`ifdef DTE_HWOPT_READ_EN
    task automatic test_hwopt();
        logic [10:0] obs, exp;
        hw_options = {5'b00110, 13'd4001};
        if0.cmd_valid = 1'b1; if0.cmd_func = 7'o177; if0.cmd_wdata = 36'o0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) if0.cmd_valid = 1'b0;
            obs = {if0.ebus_func, if0.ebus_diag_strobe, if0.ebus_driving, if0.resp_valid, if0.cmd_ready};
            exp = {7'o000, 1'b0, 1'b0, (c == 2), (c == 3)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL hwopt_c%0d obs=%b exp=%b", c, obs, exp);
            end
            if (c == 2) begin
                checks++;
                if (if0.resp_rdata !== 36'o000000_147641) begin
                    errors++; $display("FAIL hwopt_rdata got=%o exp=%o", if0.resp_rdata, 36'o000000_147641);
                end
            end
        end
    endtask
`else
    task automatic test_hwopt();
        logic [10:0] obs, exp;
        hw_options = {5'b00110, 13'd4001};
        if0.cmd_valid = 1'b1; if0.cmd_func = 7'o177; if0.cmd_wdata = 36'o0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) if0.cmd_valid = 1'b0;
            if0.ebus_data_in = (c == 3) ? 36'o525252_252525 : 36'o0;
            obs = {if0.ebus_func, if0.ebus_diag_strobe, if0.ebus_driving, if0.resp_valid, if0.cmd_ready};
            exp = {(c <= 4) ? 7'o177 : 7'o000, (c == 2 || c == 3), 1'b0, (c == 5), 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL f177_c%0d obs=%b exp=%b", c, obs, exp);
            end
        end
        checks++;
        if (if0.resp_rdata !== 36'o525252_252525) begin
            errors++; $display("FAIL f177_rdata got=%o exp=%o", if0.resp_rdata, 36'o525252_252525);
        end
        tick();
    endtask
`endif

    task automatic test_sweep();
        logic [10:0] obs, exp;
        int nstb, lat;
        nstb = 0; lat = -1;
        if1.cmd_valid = 1'b1; if1.cmd_func = 7'o010; if1.cmd_wdata = 36'o777777_000000;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) if1.cmd_valid = 1'b0;
            if (if1.ebus_diag_strobe === 1'b1) nstb++;
            if (if1.resp_valid === 1'b1 && lat < 0) lat = c;
            obs = {if1.ebus_func, if1.ebus_diag_strobe, if1.ebus_driving, if1.resp_valid, if1.cmd_ready};
            exp = {(c <= 5) ? 7'o010 : 7'o000, (c <= 4), (c <= 5), (c == 6), (c == 7)};
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL sweep_c%0d obs=%b exp=%b", c, obs, exp);
            end
        end
        checks++;
        if (nstb != 4 || lat != 6) begin
            errors++; $display("FAIL sweep_timing strobes=%0d lat=%0d exp 4/6", nstb, lat);
        end
    endtask

    initial begin
        if0.cmd_valid = 1'b0; if0.cmd_func = '0; if0.cmd_wdata = '0; if0.ebus_data_in = '0;
        if1.cmd_valid = 1'b0; if1.cmd_func = '0; if1.cmd_wdata = '0; if1.ebus_data_in = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back_busy();
        test_reset_mid_write();
        test_hwopt();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dte_diag_port
`default_nettype wire
